// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control FSM:
// state encodings, opcode/funct fields, ALU codes and mux selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic SRC_A_PC  = 1'b0;
  localparam logic SRC_A_REG = 1'b1;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_ALUOUT = 1'b1;

  // States that sit on a memory handshake and are timed out.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_cntrl_decode.sv
// R-type funct to ALU operation decode; flags
// functs the datapath does not implement.
module alu_cntrl_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] func_in,
  output logic [3:0] alu_cntrl_out,
  output logic       legal_out
);

  always_comb begin
    alu_cntrl_out = ALU_AND;
    legal_out     = 1'b1;
    unique case (1'b1)
      (func_in == FN_ADD): alu_cntrl_out = ALU_ADD;
      (func_in == FN_SUB): alu_cntrl_out = ALU_SUB;
      (func_in == FN_AND): alu_cntrl_out = ALU_AND;
      (func_in == FN_OR):  alu_cntrl_out = ALU_OR;
      (func_in == FN_SLT): alu_cntrl_out = ALU_SLT;
      default:             legal_out     = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with memory
// handshake timeout and sticky fault state.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_in,
  input  logic [5:0] func_in,
  input  logic       mem_ready_in,
  output logic       mem_req_out,
  output logic       mem_write_out,
  output logic       i_or_d_out,
  output logic       ir_write_out,
  output logic       pc_write_out,
  output logic       pc_write_cond_out,
  output logic [1:0] pc_source_out,
  output logic       alu_src_a_out,
  output logic [1:0] alu_src_b_out,
  output logic [3:0] alu_cntrl_out,
  output logic       reg_write_out,
  output logic       reg_dst_out,
  output logic       mem_to_reg_out,
  output logic       instr_done_out,
  output logic       fault_out,
  output logic [3:0] state_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          rdy;
  logic          timeout;
  logic [3:0]    r_alu;
  logic          r_legal;

  alu_cntrl_decode u_alu_dec (
    .func_in       (func_in),
    .alu_cntrl_out (r_alu),
    .legal_out     (r_legal)
  );

  // A completion seen while reset is held must not load IR/PC.
  assign rdy       = mem_ready_in & ~rst;
  assign timeout   = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign state_out = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    wait_cnt_nxt      = '0;
    mem_req_out       = 1'b0;
    mem_write_out     = 1'b0;
    i_or_d_out        = ADDR_PC;
    ir_write_out      = 1'b0;
    pc_write_out      = 1'b0;
    pc_write_cond_out = 1'b0;
    pc_source_out     = PC_SRC_ALU;
    alu_src_a_out     = SRC_A_PC;
    alu_src_b_out     = SRC_B_REG;
    alu_cntrl_out     = ALU_AND;
    reg_write_out     = 1'b0;
    reg_dst_out       = 1'b0;
    mem_to_reg_out    = 1'b0;
    instr_done_out    = 1'b0;
    fault_out         = 1'b0;

    unique case (state)
      S_FETCH: begin
        mem_req_out   = 1'b1;
        alu_src_b_out = SRC_B_FOUR;
        alu_cntrl_out = ALU_ADD;
        ir_write_out  = rdy;
        pc_write_out  = rdy;
        if (rdy) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_out = SRC_B_IMM_SH;
        alu_cntrl_out = ALU_ADD;
        unique case (1'b1)
          (op_in == OP_RTYPE && r_legal):   state_nxt = S_R_EXEC;
          (op_in == OP_LW || op_in == OP_SW): state_nxt = S_MEM_ADDR;
          (op_in == OP_ADDI):               state_nxt = S_I_EXEC;
          (op_in == OP_BEQ):                state_nxt = S_BRANCH;
          (op_in == OP_J):                  state_nxt = S_JUMP;
          default:                          state_nxt = S_FAULT;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_out = SRC_A_REG;
        alu_src_b_out = SRC_B_IMM;
        alu_cntrl_out = ALU_ADD;
        state_nxt = (op_in == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_out = 1'b1;
        i_or_d_out  = ADDR_ALUOUT;
        if (rdy) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_out  = 1'b1;
        mem_to_reg_out = 1'b1;
        instr_done_out = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_out    = 1'b1;
        mem_write_out  = 1'b1;
        i_or_d_out     = ADDR_ALUOUT;
        instr_done_out = rdy;
        if (rdy) state_nxt = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a_out = SRC_A_REG;
        alu_src_b_out = SRC_B_REG;
        alu_cntrl_out = r_alu;
        state_nxt     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_out  = 1'b1;
        reg_dst_out    = 1'b1;
        instr_done_out = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a_out = SRC_A_REG;
        alu_src_b_out = SRC_B_IMM;
        alu_cntrl_out = ALU_ADD;
        state_nxt     = S_I_WB;
      end
      S_I_WB: begin
        reg_write_out  = 1'b1;
        instr_done_out = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_out     = SRC_A_REG;
        alu_src_b_out     = SRC_B_REG;
        alu_cntrl_out     = ALU_SUB;
        pc_write_cond_out = 1'b1;
        pc_source_out     = PC_SRC_ALUOUT;
        instr_done_out    = 1'b1;
        state_nxt         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_out   = 1'b1;
        pc_source_out  = PC_SRC_JUMP;
        instr_done_out = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_FAULT: begin
        fault_out = 1'b1;
      end
      default: begin
        state_nxt = S_FAULT;
      end
    endcase

    // Completion on the limit edge wins over the timeout.
    if (is_mem_wait(state) && !rdy) begin
      if (timeout) state_nxt = S_FAULT;
      else wait_cnt_nxt = wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: instruction
// sequences from a table plus reset, fault and timeout corners.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] op_in;
  logic [5:0] func_in;
  logic       mem_ready_in;
  logic       mem_req_out;
  logic       mem_write_out;
  logic       i_or_d_out;
  logic       ir_write_out;
  logic       pc_write_out;
  logic       pc_write_cond_out;
  logic [1:0] pc_source_out;
  logic       alu_src_a_out;
  logic [1:0] alu_src_b_out;
  logic [3:0] alu_cntrl_out;
  logic       reg_write_out;
  logic       reg_dst_out;
  logic       mem_to_reg_out;
  logic       instr_done_out;
  logic       fault_out;
  logic [3:0] state_out;

  multicycle_control #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .op_in             (op_in),
    .func_in           (func_in),
    .mem_ready_in      (mem_ready_in),
    .mem_req_out       (mem_req_out),
    .mem_write_out     (mem_write_out),
    .i_or_d_out        (i_or_d_out),
    .ir_write_out      (ir_write_out),
    .pc_write_out      (pc_write_out),
    .pc_write_cond_out (pc_write_cond_out),
    .pc_source_out     (pc_source_out),
    .alu_src_a_out     (alu_src_a_out),
    .alu_src_b_out     (alu_src_b_out),
    .alu_cntrl_out     (alu_cntrl_out),
    .reg_write_out     (reg_write_out),
    .reg_dst_out       (reg_dst_out),
    .mem_to_reg_out    (mem_to_reg_out),
    .instr_done_out    (instr_done_out),
    .fault_out         (fault_out),
    .state_out         (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] func;
    logic       rdy;
    logic [3:0] st;
    logic [19:0] ctl;
  } vec_t;

  vec_t vq[$];
  int   nvec;
  int   nbad;

  logic [19:0] act;
  assign act = {mem_req_out, mem_write_out, i_or_d_out,
                ir_write_out, pc_write_out, pc_write_cond_out,
                pc_source_out, alu_src_a_out, alu_src_b_out,
                alu_cntrl_out, reg_write_out, reg_dst_out,
                mem_to_reg_out, instr_done_out, fault_out};

  function automatic logic [19:0] c(
    input logic req, wr, iord, irw, pcw, pcwc,
    input logic [1:0] pcs,
    input logic sa,
    input logic [1:0] sb,
    input logic [3:0] alu,
    input logic rw, rd, m2r, done, flt);
    return {req, wr, iord, irw, pcw, pcwc, pcs, sa, sb,
            alu, rw, rd, m2r, done, flt};
  endfunction

  logic [19:0] F1, F0, DEC, MA, MRD, MWB, MWR0, MWR1;
  logic [19:0] RWB, IWB, BR, JMP, FLT;

  function automatic logic [19:0] rex(input logic [3:0] alu);
    return c(0,0,0,0,0,0,2'b00,1,2'b00,alu,0,0,0,0,0);
  endfunction

  task automatic check(input string nm, input logic [3:0] st,
                       input logic [19:0] ctl);
    nvec++;
    if (state_out !== st || act !== ctl) begin
      nbad++;
      $display("FAIL %s: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
               nm, state_out, act, st, ctl);
    end
  endtask

  task automatic step(input string nm, input logic [5:0] op,
                      input logic [5:0] func, input logic rdy,
                      input logic [3:0] st, input logic [19:0] ctl);
    @(negedge clk);
    op_in = op;
    func_in = func;
    mem_ready_in = rdy;
    #1;
    check(nm, st, ctl);
  endtask

  task automatic add(input string nm, input logic [5:0] op,
                     input logic [5:0] func, input logic rdy,
                     input logic [3:0] st, input logic [19:0] ctl);
    vec_t v;
    v.nm = nm; v.op = op; v.func = func;
    v.rdy = rdy; v.st = st; v.ctl = ctl;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic add_r(input string nm, input logic [5:0] fn,
                       input logic [3:0] alu);
    add({nm, "_f"},   6'b000000, fn, 1, 4'd0, F1);
    add({nm, "_dec"}, 6'b000000, fn, 1, 4'd1, DEC);
    add({nm, "_ex"},  6'b000000, fn, 1, 4'd6, rex(alu));
    add({nm, "_wb"},  6'b000000, fn, 1, 4'd7, RWB);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nvec = 0;
    nbad = 0;
    rst = 1'b0;
    op_in = '0;
    func_in = '0;
    mem_ready_in = 1'b1;

    F1   = c(1,0,0,1,1,0,2'b00,0,2'b01,4'b0010,0,0,0,0,0);
    F0   = c(1,0,0,0,0,0,2'b00,0,2'b01,4'b0010,0,0,0,0,0);
    DEC  = c(0,0,0,0,0,0,2'b00,0,2'b11,4'b0010,0,0,0,0,0);
    MA   = c(0,0,0,0,0,0,2'b00,1,2'b10,4'b0010,0,0,0,0,0);
    MRD  = c(1,0,1,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0);
    MWB  = c(0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,0,1,1,0);
    MWR0 = c(1,1,1,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0);
    MWR1 = c(1,1,1,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,1,0);
    RWB  = c(0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,1,0,1,0);
    IWB  = c(0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,0,0,1,0);
    BR   = c(0,0,0,0,0,1,2'b01,1,2'b00,4'b0110,0,0,0,1,0);
    JMP  = c(0,0,0,0,1,0,2'b10,0,2'b00,4'b0000,0,0,0,1,0);
    FLT  = c(0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,1);

    add_r("add", 6'b100000, 4'b0010);
    add_r("sub", 6'b100010, 4'b0110);
    add_r("and", 6'b100100, 4'b0000);
    add_r("or",  6'b100101, 4'b0001);
    add_r("slt", 6'b101010, 4'b0111);
    add("lw_f",   6'b100011, 0, 1, 4'd0, F1);
    add("lw_dec", 6'b100011, 0, 1, 4'd1, DEC);
    add("lw_ma",  6'b100011, 0, 1, 4'd2, MA);
    add("lw_rd0", 6'b100011, 0, 0, 4'd3, MRD);
    add("lw_rd1", 6'b100011, 0, 0, 4'd3, MRD);
    add("lw_rd2", 6'b100011, 0, 0, 4'd3, MRD);
    add("lw_rd3", 6'b100011, 0, 1, 4'd3, MRD);
    add("lw_wb",  6'b100011, 0, 1, 4'd4, MWB);
    add("sw_f",   6'b101011, 0, 1, 4'd0, F1);
    add("sw_dec", 6'b101011, 0, 1, 4'd1, DEC);
    add("sw_ma",  6'b101011, 0, 1, 4'd2, MA);
    add("sw_wr0", 6'b101011, 0, 0, 4'd5, MWR0);
    add("sw_wr1", 6'b101011, 0, 1, 4'd5, MWR1);
    add("addi_f",   6'b001000, 0, 1, 4'd0,  F1);
    add("addi_dec", 6'b001000, 0, 1, 4'd1,  DEC);
    add("addi_ex",  6'b001000, 0, 1, 4'd10, MA);
    add("addi_wb",  6'b001000, 0, 1, 4'd11, IWB);
    add("beq_f",   6'b000100, 0, 1, 4'd0, F1);
    add("beq_dec", 6'b000100, 0, 1, 4'd1, DEC);
    add("beq_br",  6'b000100, 0, 1, 4'd8, BR);
    add("j_f",     6'b000010, 0, 1, 4'd0, F1);
    add("j_dec",   6'b000010, 0, 1, 4'd1, DEC);
    add("j_jmp",   6'b000010, 0, 1, 4'd9, JMP);
    add("f_wait",  6'b111111, 0, 0, 4'd0, F0);
    add("ill_f",   6'b111111, 0, 1, 4'd0, F1);
    add("ill_dec", 6'b111111, 0, 1, 4'd1, DEC);
    add("ill_flt", 6'b111111, 0, 1, 4'd12, FLT);

    // Async reset with ready high: FETCH values, no IR/PC load.
    #1 rst = 1'b1;
    #1 check("reset", 4'd0, F0);
    do_reset();

    for (int i = 0; i < vq.size(); i++)
      step(vq[i].nm, vq[i].op, vq[i].func, vq[i].rdy,
           vq[i].st, vq[i].ctl);

    for (int i = 0; i < 20; i++)
      step("fault_hold", 6'b000000, 6'b100000, i[0], 4'd12, FLT);

    @(negedge clk);
    mem_ready_in = 1'b1;
    rst = 1'b1;
    #1 check("fault_rst", 4'd0, F0);
    do_reset();

    step("fn_f",   6'b000000, 6'b000111, 1, 4'd0,  F1);
    step("fn_dec", 6'b000000, 6'b000111, 1, 4'd1,  DEC);
    step("fn_flt", 6'b000000, 6'b000111, 1, 4'd12, FLT);

    do_reset();
    for (int i = 1; i <= 16; i++)
      step("to_wait", 6'b000000, 6'b100000, 0, 4'd0, F0);
    step("to_fault", 6'b000000, 6'b100000, 0, 4'd12, FLT);

    do_reset();
    for (int i = 1; i <= 15; i++)
      step("to_wait2", 6'b000000, 6'b100000, 0, 4'd0, F0);
    step("to_last", 6'b000000, 6'b100000, 1, 4'd0, F1);
    step("to_dec",  6'b000000, 6'b100000, 0, 4'd1, DEC);

    do_reset();
    step("swr_f",   6'b101011, 0, 1, 4'd0, F1);
    step("swr_dec", 6'b101011, 0, 1, 4'd1, DEC);
    step("swr_ma",  6'b101011, 0, 1, 4'd2, MA);
    step("swr_w",   6'b101011, 0, 0, 4'd5, MWR0);
    #1 rst = 1'b1;
    #1 check("swr_rst", 4'd0, F0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Clock/reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum memory-wait cycles before fault.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 op_in  in  6  opcode from instruction register; valid from DECODE onward.
REQ-006 func_in  in  6  funct field from instruction register; valid from DECODE onward.
REQ-007 mem_ready_in  in  1  memory completes the requested transfer on this clock edge.
REQ-008 mem_req_out  out  1  memory request; held until the completing edge.
REQ-009 mem_write_out  out  1  request is a write.
REQ-010 i_or_d_out  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 ir_write_out  out  1  load the instruction register.
REQ-012 pc_write_out  out  1  unconditional PC load.
REQ-013 pc_write_cond_out  out  1  PC load if ALU zero.
REQ-014 pc_source_out  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-015 alu_src_a_out  out  1  ALU A input: 0 = PC, 1 = register A.
REQ-016 alu_src_b_out  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-017 alu_cntrl_out  out  4  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
REQ-018 reg_write_out / reg_dst_out / mem_to_reg_out  out  1 each  register-file write enable; destination select (1 = rd); write-data select (1 = MDR).
REQ-019 instr_done_out / fault_out / state_out  out  1/1/4  pulse on an instruction's final cycle; sticky fault flag; current state encoding.

Function
REQ-020 States and encodings SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, FAULT 12.
REQ-021 Outputs not listed for a state SHALL be 0.
REQ-022 FETCH: mem_req=1, i_or_d=0, src_a=0, src_b=01, ALU=ADD.
- ir_write and pc_write equal mem_ready_in.
- Go to DECODE on mem_ready_in, otherwise stay.
REQ-023 DECODE: src_a=0, src_b=11, ALU=ADD. Next state by opcode:
- 000000 with funct 100000/100010/100100/100101/101010 -> R_EXEC.
- 100011 or 101011 -> MEM_ADDR.
- 001000 -> I_EXEC.
- 000100 -> BRANCH.
- 000010 -> JUMP.
- Any other opcode, or opcode 000000 with an unlisted funct -> FAULT.
REQ-024 MEM_ADDR: src_a=1, src_b=10, ALU=ADD. Next: MEM_RD for LW, MEM_WR for SW.
REQ-025 MEM_RD: mem_req=1, i_or_d=1. Go to MEM_WB on mem_ready_in.
REQ-026 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next: FETCH.
REQ-027 MEM_WR: mem_req=1, mem_write=1, i_or_d=1. instr_done=mem_ready_in. Go to FETCH on mem_ready_in.
REQ-028 R_EXEC: src_a=1, src_b=00, ALU decoded from funct. Next: R_WB.
REQ-029 R_WB: reg_write=1, reg_dst=1, instr_done=1. Next: FETCH.
REQ-030 I_EXEC: src_a=1, src_b=10, ALU=ADD. Next: I_WB.
REQ-031 I_WB: reg_write=1, reg_dst=0, instr_done=1. Next: FETCH.
REQ-032 BRANCH: src_a=1, src_b=00, ALU=SUB, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
REQ-033 JUMP: pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
REQ-034 Minimum cycles per instruction with zero memory wait: LW 5; SW, R-type and ADDI 4; BEQ and J 3.
REQ-035 Wait counter: counts consecutive cycles in FETCH/MEM_RD/MEM_WR with mem_ready_in low; clears on any state change.
- Reaching TIMEOUT_CYCLES -> FAULT.
- mem_ready_in high on the same edge the count reaches the limit -> transfer completes, no fault.
REQ-036 FAULT: fault_out=1, all control outputs 0; state held until reset.

Reset
REQ-037 On rst assertion, state SHALL go to FETCH and the wait counter to 0 immediately, without waiting for a clock edge.
REQ-038 During reset: mem_req_out=1, all other outputs at their FETCH values with mem_ready_in treated as 0, fault_out=0.
REQ-039 Reset asserted mid-wait in MEM_RD/MEM_WR SHALL abandon the transfer; mem_write_out falls asynchronously.

Structure
REQ-040 Shared package SHALL hold the state encodings, opcode/funct constants, ALU codes and mux-select codes.
REQ-041 funct-to-ALU-code mapping SHALL be the sub-module alu_cntrl_decode (combinational).

Verification
REQ-042 ADD: op 000000, func 100000, mem_ready tied 1 -> states 0,1,6,7; alu_cntrl 0010 in R_EXEC; reg_dst=1 and reg_write=1 in R_WB; instr_done on cycle 4.
REQ-043 LW with mem_ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles, i_or_d=1 throughout; MEM_WB with mem_to_reg=1; 8 cycles total.
REQ-044 BEQ: op 000100 -> ALU 0110 with pc_write_cond=1 and pc_source=01 in cycle 3; J: op 000010 -> pc_write=1 and pc_source=10 in cycle 3.
REQ-045 Illegal op 111111, then op 000000 with func 000111 -> FAULT (state 12), fault_out=1, held 20 cycles; rst clears to FETCH.
REQ-046 mem_ready held low in FETCH with TIMEOUT_CYCLES=16 -> FAULT entered on cycle 16; mem_ready rising on cycle 16 -> DECODE instead.
REQ-047 rst pulsed mid-MEM_WR -> mem_write_out falls before the next edge; state_out=0.
